// File: rtl/bus_arbiter.sv
// Central bus arbiter: priority write-back first, round-robin within each class.
// Optional grant timeout is built only when ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int N_DEV         = 4,
    parameter int ID_W          = 2,
    parameter int GRANT_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] request,
    input  logic [N_DEV-1:0] request_type,
    input  logic [N_DEV-1:0] hold,
    output logic [N_DEV-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_type,
    output logic             active,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_DEV-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_type_q, grant_type_d;
    logic              active_q, active_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [N_DEV-1:0]  candidates;
    logic [ID_W-1:0]   winId;
    logic              winFound;
    logic [ID_W:0]     searchSum;
    logic [ID_W-1:0]   searchIdx;
    logic [ID_W-1:0]   nextPtr;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
`endif

    // Search upward from rr_ptr with explicit modulo wrap so any N_DEV stays in range.
    always_comb begin
        candidates = (|(request & request_type)) ? (request & request_type) : request;
        winId      = rr_ptr_q;
        winFound   = 1'b0;
        searchSum  = '0;
        searchIdx  = '0;
        for (int i = 0; i < N_DEV; i++) begin
            searchSum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (searchSum >= (ID_W+1)'(N_DEV)) begin
                searchSum = searchSum - (ID_W+1)'(N_DEV);
            end
            searchIdx = searchSum[ID_W-1:0];
            if (!winFound && candidates[searchIdx]) begin
                winFound = 1'b1;
                winId    = searchIdx;
            end
        end
    end

    assign nextPtr = (grant_id_q == ID_W'(N_DEV-1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_id_d   = grant_id_q;
        grant_type_d = grant_type_q;
        active_d     = active_q;
        rr_ptr_d     = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        timeout_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (|request) begin
                    state_d      = GRANT;
                    grant_d      = {{(N_DEV-1){1'b0}}, 1'b1} << winId;
                    grant_id_d   = winId;
                    grant_type_d = request_type[winId];
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            GRANT: begin
                if (hold[grant_id_q]) begin
                    state_d  = BUSY;
                    active_d = 1'b1;
                end else if (!request[grant_id_q]) begin
                    // A withdrawn grant leaves rr_ptr alone: nobody used the bus.
                    state_d = IDLE;
                    grant_d = '0;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(GRANT_TIMEOUT-1)) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    rr_ptr_d  = nextPtr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            BUSY: begin
                if (!hold[grant_id_q]) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    active_d = 1'b0;
                    rr_ptr_d = nextPtr;
                end
            end
            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            grant_type_q <= 1'b0;
            active_q     <= 1'b0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_id_q   <= grant_id_d;
            grant_type_q <= grant_type_d;
            active_q     <= active_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign grant_type = grant_type_q;
    assign active     = active_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Central arbiter at the far end of the device-side arbiter interface handler. It collects bus requests from `N_DEV` devices, grants the shared bus to exactly one device, and keeps the grant while that device holds the bus. It drives the bus-wide `active` indication. Priority write-back requests are served first; requests within each class are served round-robin.

## Interface
- `N_DEV`, 4: number of requesting devices (2..8).
- `ID_W`, 2: width of `grant_id`; must satisfy 2^ID_W >= N_DEV.
- `GRANT_TIMEOUT`, 8: cycles a grant may wait for `hold` (used only with ARB_TIMEOUT_EN).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `request`  input  N_DEV  per-device bus request; 1 = requesting.
- `request_type`  input  N_DEV  per-device type; 0 = write-back, 1 = priority write-back. Valid only while the matching `request` bit is 1.
- `hold`  input  N_DEV  per-device bus hold; the grantee keeps it high for the whole transfer.
- `grant`  output  N_DEV  one-hot grant, or all zero.
- `grant_id`  output  ID_W  index of the current grantee; holds its last value when idle.
- `grant_type`  output  1  `request_type` of the grantee, latched at grant.
- `active`  output  1  bus busy; 1 while the grantee holds the bus.
- `timeout`  output  1  one-cycle pulse when a grant is revoked for an unanswered hold.

## Operation
- States:
  - IDLE: `grant` = 0, `active` = 0.
  - GRANT: `grant` one-hot, `active` = 0, waiting for `hold`.
  - BUSY: `grant` one-hot, `active` = 1.
- IDLE:
  - No `request` bits set: stay in IDLE.
  - Any `request` bit set: select a winner, then go to GRANT.
  - Winner selection:
    - Candidate set is `request & request_type` if that is nonzero, otherwise `request`.
    - Winner is the first candidate found searching upward from `rr_ptr`, wrapping from N_DEV-1 to 0.
    - Latch `grant_id`, `grant_type` and the one-hot `grant` for the winner.
- GRANT, checked in this order:
  - `hold[g]` = 1: go to BUSY.
  - `request[g]` = 0: withdrawal; clear `grant` and return to IDLE. `rr_ptr` is unchanged.
  - Otherwise stay in GRANT.
- BUSY:
  - Stay while `hold[g]` = 1. Requests from other devices are ignored.
  - `hold[g]` = 0: clear `grant` and `active`, set `rr_ptr` = (g+1) mod N_DEV, go to IDLE.
- Changes to `request_type` after the grant do not alter `grant_type`.
- `hold` bits from non-grantees are ignored in every state.
- `rr_ptr` is ID_W bits wide. Wrap is explicit modulo N_DEV, so non-power-of-two N_DEV never produces an out-of-range index.
- Reset, including mid-transfer: state = IDLE, `grant` = 0, `grant_id` = 0, `grant_type` = 0, `active` = 0, `timeout` = 0, `rr_ptr` = 0, timeout counter = 0.

## Timing
- Request to grant: `request` seen at edge k gives `grant` valid after edge k (1-cycle latency).
- Hold to active: `hold[g]` seen at edge m gives `active` = 1 after edge m.
- Release: `hold[g]` falling seen at edge n clears `grant` and `active` after edge n. The earliest next grant is after edge n+1, so there is a minimum one-cycle bus turnaround.
- Devices sample `grant` on the falling clock edge. All arbiter outputs are registered and stable across the falling edge.
- When a request and a release happen in the same cycle, the release is taken first and the new arbitration occurs in IDLE on the next edge.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter runs in GRANT, starting at 0 on entry.
  - If `hold[g]` is still 0 after GRANT_TIMEOUT cycles in GRANT, `grant` is cleared and `timeout` pulses for one cycle.
  - `rr_ptr` advances past g, then the state returns to IDLE.
  - BUSY duration is unbounded.
- `ARB_TIMEOUT_EN` not defined: no counter is built, `timeout` is tied to 0, and GRANT waits indefinitely.

## Test plan
- Single requester:
  - Stimulus: release reset; `request` = 4'b0100, type 0; `hold[2]` high 2 cycles after grant for 3 cycles, then low.
  - Response: `grant` = 4'b0100 one cycle after request; `grant_id` = 2; `active` high 3 cycles; `grant` = 0 one cycle after `hold` falls.
- Round-robin:
  - Stimulus: `request` = 4'b1111 held, all type 0, each grantee holds 2 cycles.
  - Response: grant order 0,1,2,3,0; `rr_ptr` wraps.
- Priority:
  - Stimulus: `request` = 4'b0011 with `request_type` = 4'b0010, `rr_ptr` = 0.
  - Response: device 1 granted first with `grant_type` = 1; device 0 granted next.
- Withdrawal:
  - Stimulus: device 3 granted, then drops `request` before `hold`.
  - Response: `grant` = 0 next cycle, `active` never asserted, `rr_ptr` unchanged.
- Reset mid-BUSY:
  - Stimulus: assert `rst` = 0 asynchronously while `active` = 1.
  - Response: `grant`, `active`, `grant_id` = 0 immediately, without waiting for a clock edge.
- Timeout (ARB_TIMEOUT_EN):
  - Stimulus: device 1 granted, `hold` never asserted, `request` held.
  - Response: `timeout` pulses after 8 GRANT cycles, `grant` cleared; device 2 is granted next if requesting.
